// File: rtl/combined_filter_pkg.sv
// Shared types, widths and helpers for the PDM-to-PCM decimator.
//   CIC_R/CIC_N  : CIC decimation ratio and stage count
//   CIC_W/ACC_W  : CIC integrator width and FIR accumulator width
//   FIR_COEF     : 7-tap half-band coefficients (sum 32, unity DC gain)
//   PDM_P1/M1    : 2-bit signed codes for PDM +1 / -1
//   sat16()      : clamp an ACC_W signed value into the 16-bit PCM range
package combined_filter_pkg;

    localparam int unsigned CIC_R     = 32;
    localparam int unsigned CIC_N     = 4;
    localparam int unsigned OUT_W     = 16;
    localparam int unsigned CIC_W     = 22;
    localparam int unsigned ACC_W     = 24;
    localparam int unsigned CNT_W     = $clog2(CIC_R);
    localparam int unsigned PDM_W     = 2;
    localparam int unsigned ERR_W     = 2;
    localparam int unsigned FIR_TAPS  = 7;
    localparam int unsigned COEF_W    = 6;
    localparam int unsigned CIC_SHIFT = 5;
    localparam int unsigned FIR_SHIFT = 5;

    localparam logic [PDM_W-1:0] PDM_P1 = 2'b01;
    localparam logic [PDM_W-1:0] PDM_M1 = 2'b11;

    typedef logic signed [COEF_W-1:0] coef_t;

    localparam coef_t FIR_COEF [FIR_TAPS] =
        '{-6'sd1, 6'sd0, 6'sd9, 6'sd16, 6'sd9, 6'sd0, -6'sd1};

    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'(32767);
    localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(-32768);

    // One output beat: PCM sample plus the frame's accumulated error flags
    typedef struct packed {
        logic signed [OUT_W-1:0] data;
        logic [ERR_W-1:0]        error;
    } pcm_beat_t;

    // Clamp to the signed 16-bit range
    function automatic logic signed [OUT_W-1:0] sat16(input logic signed [ACC_W-1:0] x);
        logic signed [OUT_W-1:0] r;
        if (x > SAT_MAX) begin
            r = 16'sh7fff;
        end else if (x < SAT_MIN) begin
            r = 16'sh8000;
        end else begin
            r = x[OUT_W-1:0];
        end
        return r;
    endfunction

endpackage

// File: rtl/combined_filter_cic_decimator.sv
// 4-stage CIC decimate-by-32 with >>>5 scaling and 16-bit saturation.
//   clk_clk      : PDM clock
//   reset_reset  : synchronous active-high reset
//   accept       : input sample consumed this cycle
//   pdm          : signed 2-bit PDM sample
//   wrap_c       : combinational, high on the accept that completes a CIC block
//   cic_data     : scaled, saturated CIC output (registered)
//   cic_valid    : one-cycle strobe, high the cycle cic_data is new
module cic_decimator
    import combined_filter_pkg::*;
(
    input  logic                    clk_clk,
    input  logic                    reset_reset,
    input  logic                    accept,
    input  logic signed [PDM_W-1:0] pdm,
    output logic                    wrap_c,
    output logic signed [OUT_W-1:0] cic_data,
    output logic                    cic_valid
);

    logic signed [CIC_W-1:0] integ_q    [CIC_N];
    logic signed [CIC_W-1:0] integ_d    [CIC_N];
    logic signed [CIC_W-1:0] comb_dly_q [CIC_N];
    logic signed [CIC_W-1:0] comb_dly_d [CIC_N];
    logic signed [CIC_W-1:0] comb_out_c;
    logic signed [ACC_W-1:0] cic_wide_c;
    logic signed [OUT_W-1:0] cic_scaled_c;
    logic [CNT_W-1:0]        cnt_q;
    logic                    comb_pend_q;

    assign wrap_c = accept && (cnt_q == CNT_W'(CIC_R - 1));

    // Integrator cascade; each stage adds the freshly updated value of the stage before
    always_comb begin : integrate
        logic signed [CIC_W-1:0] run;
        run = CIC_W'(pdm);
        for (int k = 0; k < CIC_N; k++) begin
            run        = integ_q[k] + run;
            integ_d[k] = run;
        end
    end

    // Comb cascade (M=1) at the decimated rate; each delay stores its own stage input
    always_comb begin : comb_chain
        logic signed [CIC_W-1:0] run;
        run = integ_q[CIC_N-1];
        for (int k = 0; k < CIC_N; k++) begin
            comb_dly_d[k] = run;
            run           = run - comb_dly_q[k];
        end
        comb_out_c = run;
    end

    // Full-scale CIC output is +/-2^20; >>>5 brings it to the 16-bit range (+2^20 saturates)
    always_comb begin : scale
        cic_wide_c   = ACC_W'(comb_out_c);
        cic_scaled_c = sat16(cic_wide_c >>> CIC_SHIFT);
    end

    // Integrators/counter advance on accept; combs register the edge after the block wraps
    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            integ_q     <= '{default: '0};
            comb_dly_q  <= '{default: '0};
            cnt_q       <= '0;
            comb_pend_q <= 1'b0;
            cic_data    <= '0;
            cic_valid   <= 1'b0;
        end else begin
            if (accept) begin
                integ_q <= integ_d;
                cnt_q   <= cnt_q + CNT_W'(1);
            end
            comb_pend_q <= wrap_c;
            cic_valid   <= comb_pend_q;
            if (comb_pend_q) begin
                comb_dly_q <= comb_dly_d;
                cic_data   <= cic_scaled_c;
            end
        end
    end

endmodule

// File: rtl/combined_filter.sv
// Per-microphone PDM-to-PCM decimator: CIC /32 followed by 7-tap half-band FIR /2.
//   clk_clk          : 2 MHz PDM clock
//   reset_reset      : synchronous active-high reset
//   av_st_in_data    : signed 2-bit PDM sample
//   av_st_in_valid   : sample qualifier
//   av_st_in_ready   : low only while reset is asserted
//   av_st_in_error   : error flags accompanying the input sample
//   av_st_out_data   : signed 16-bit PCM sample, held between pulses
//   av_st_out_valid  : one-cycle pulse per output sample
//   av_st_out_error  : OR of input error flags over the frame's accepted samples
module combined_filter
    import combined_filter_pkg::*;
(
    input  logic             clk_clk,
    input  logic             reset_reset,
    input  logic [PDM_W-1:0] av_st_in_data,
    input  logic             av_st_in_valid,
    output logic             av_st_in_ready,
    input  logic [ERR_W-1:0] av_st_in_error,
    output logic [OUT_W-1:0] av_st_out_data,
    output logic             av_st_out_valid,
    output logic [ERR_W-1:0] av_st_out_error
);

    logic                    accept_c;
    logic                    wrap_c;
    logic                    frame_end_c;
    logic signed [PDM_W-1:0] pdm_c;
    logic signed [OUT_W-1:0] cic_data;
    logic                    cic_valid;

    logic                    half_q;
    logic                    fe_d1_q;
    logic                    fe_d2_q;
    logic [ERR_W-1:0]        err_acc_q;
    logic [ERR_W-1:0]        err_frame_q;
    logic signed [OUT_W-1:0] hist_q [FIR_TAPS-1];
    logic signed [OUT_W-1:0] taps_c [FIR_TAPS];
    logic signed [ACC_W-1:0] fir_acc_c;
    logic signed [OUT_W-1:0] fir_c;
    pcm_beat_t               out_q;
    logic                    out_valid_q;

    assign accept_c = av_st_in_valid && !reset_reset;
    assign pdm_c    = $signed(av_st_in_data);

    // Ready follows reset directly so it is already low in the first reset cycle
    assign av_st_in_ready = ~reset_reset;

    cic_decimator u_cic (
        .clk_clk     (clk_clk),
        .reset_reset (reset_reset),
        .accept      (accept_c),
        .pdm         (pdm_c),
        .wrap_c      (wrap_c),
        .cic_data    (cic_data),
        .cic_valid   (cic_valid)
    );

    // A frame is two CIC blocks; it ends on the wrap of the second block
    assign frame_end_c = wrap_c && half_q;

    // FIR taps: newest CIC sample plus the six previous ones
    always_comb begin : fir_taps
        taps_c[0] = cic_data;
        for (int k = 1; k < FIR_TAPS; k++) begin
            taps_c[k] = hist_q[k-1];
        end
    end

    // Half-band MAC, then >>>5 (coefficient sum 32) and saturate
    always_comb begin : fir_mac
        fir_acc_c = '0;
        for (int k = 0; k < FIR_TAPS; k++) begin
            fir_acc_c = fir_acc_c + ACC_W'(taps_c[k]) * ACC_W'(FIR_COEF[k]);
        end
        fir_c = sat16(fir_acc_c >>> FIR_SHIFT);
    end

    // Frame tracking, error accumulation, FIR history and output register
    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            half_q      <= 1'b0;
            fe_d1_q     <= 1'b0;
            fe_d2_q     <= 1'b0;
            err_acc_q   <= '0;
            err_frame_q <= '0;
            hist_q      <= '{default: '0};
            out_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            if (wrap_c) begin
                half_q <= ~half_q;
            end
            if (accept_c) begin
                err_acc_q <= frame_end_c ? '0 : (err_acc_q | av_st_in_error);
            end
            // Snapshot the frame's flags at its last accept, before the accumulator clears
            if (frame_end_c) begin
                err_frame_q <= err_acc_q | av_st_in_error;
            end
            // fe_d2_q lines up with the CIC strobe carrying the frame's second block
            fe_d1_q <= frame_end_c;
            fe_d2_q <= fe_d1_q;
            if (cic_valid) begin
                hist_q[0] <= cic_data;
                for (int k = 1; k < FIR_TAPS - 1; k++) begin
                    hist_q[k] <= hist_q[k-1];
                end
            end
            out_valid_q <= fe_d2_q;
            if (fe_d2_q) begin
                out_q.data  <= fir_c;
                out_q.error <= err_frame_q;
            end
        end
    end

    assign av_st_out_data  = out_q.data;
    assign av_st_out_error = out_q.error;
    assign av_st_out_valid = out_valid_q;

endmodule

// File: tb/tb_combined_filter.sv
// Self-checking bench for combined_filter: directed scenarios plus random traffic,
// compared every cycle against a convolution-based model of the decimator.
module tb_combined_filter;
    import combined_filter_pkg::*;

    logic       clk_clk = 1'b0;
    logic       reset_reset = 1'b1;
    logic [1:0] av_st_in_data = 2'b00;
    logic       av_st_in_valid = 1'b0;
    logic       av_st_in_ready;
    logic [1:0] av_st_in_error = 2'b00;
    logic [15:0] av_st_out_data;
    logic       av_st_out_valid;
    logic [1:0] av_st_out_error;

    combined_filter dut (
        .clk_clk         (clk_clk),
        .reset_reset     (reset_reset),
        .av_st_in_data   (av_st_in_data),
        .av_st_in_valid  (av_st_in_valid),
        .av_st_in_ready  (av_st_in_ready),
        .av_st_in_error  (av_st_in_error),
        .av_st_out_data  (av_st_out_data),
        .av_st_out_valid (av_st_out_valid),
        .av_st_out_error (av_st_out_error)
    );

    always #5 clk_clk = ~clk_clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int drv_edge = 0;

    // Model: CIC impulse response = (32-sample boxcar)^4, 125 taps
    int h [125];
    int xh [125];
    int cq [7];
    int acc_cnt = 0;
    int errm = 0;
    localparam int COEF [7] = '{-1, 0, 9, 16, 9, 0, -1};

    typedef struct {
        int due;
        int data;
        int err;
    } exp_t;
    exp_t expq [$];
    exp_t ehead;
    logic exp_valid = 1'b0;
    int   exp_data = 0;
    int   exp_err = 0;

    int pulse_cyc [$];
    int pulse_dat [$];
    int pulse_err [$];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: actual=%0d expected=%0d", name, cyc, act, exp);
        end
    endtask

    function automatic int sat(input int x);
        if (x > 32767) return 32767;
        if (x < -32768) return -32768;
        return x;
    endfunction

    function automatic int qget(input int q [$], input int i);
        if (i < q.size()) return q[i];
        return -999999;
    endfunction

    // Reference model evaluated at each rising edge from the inputs presented to it
    always @(posedge clk_clk) begin
        int v;
        int cic;
        int fir;
        cyc++;
        exp_valid = 1'b0;
        if (reset_reset) begin
            for (int i = 0; i < 125; i++) xh[i] = 0;
            for (int i = 0; i < 7; i++) cq[i] = 0;
            acc_cnt = 0;
            errm = 0;
            exp_data = 0;
            exp_err = 0;
            expq.delete();
        end else begin
            if (expq.size() > 0 && expq[0].due == cyc) begin
                ehead = expq.pop_front();
                exp_valid = 1'b1;
                exp_data = ehead.data;
                exp_err = ehead.err;
            end
            if (av_st_in_valid) begin
                v = av_st_in_data[1] ? int'(av_st_in_data) - 4 : int'(av_st_in_data);
                for (int i = 124; i > 0; i--) xh[i] = xh[i-1];
                xh[0] = v;
                errm = errm | int'(av_st_in_error);
                acc_cnt++;
                if (acc_cnt % 32 == 0) begin
                    cic = 0;
                    for (int j = 0; j < 125; j++) cic += h[j] * xh[j];
                    for (int i = 6; i > 0; i--) cq[i] = cq[i-1];
                    cq[0] = sat(cic >>> 5);
                    if (acc_cnt == 64) begin
                        fir = 0;
                        for (int k = 0; k < 7; k++) fir += COEF[k] * cq[k];
                        expq.push_back('{due: cyc + 2, data: sat(fir >>> 5), err: errm});
                        errm = 0;
                        acc_cnt = 0;
                    end
                end
            end
        end
    end

    // Compare process: every cycle, away from the active edge
    always @(negedge clk_clk) begin
        chk("in_ready", int'(av_st_in_ready), int'(!reset_reset));
        chk("out_valid", int'(av_st_out_valid), int'(exp_valid));
        chk("out_data", int'($signed(av_st_out_data)), exp_data);
        chk("out_error", int'(av_st_out_error), exp_err);
        if (av_st_out_valid) begin
            pulse_cyc.push_back(cyc);
            pulse_dat.push_back(int'($signed(av_st_out_data)));
            pulse_err.push_back(int'(av_st_out_error));
        end
    end

    task automatic step(input logic r, input logic v, input logic [1:0] d, input logic [1:0] e);
        @(posedge clk_clk);
        #1;
        reset_reset = r;
        av_st_in_valid = v;
        av_st_in_data = d;
        av_st_in_error = e;
        drv_edge = cyc + 1;
    endtask

    task automatic do_reset(input int n);
        repeat (n) step(1'b1, 1'b1, PDM_P1, 2'b11);
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 1'b0, 2'(PDM_M1), 2'b00);
    endtask

    // mode 0: +1, 1: -1, 2: alternating +1/-1
    task automatic run(input int n, input int mode, output int first_e, output int last_e);
        logic [1:0] d;
        first_e = 0;
        last_e = 0;
        for (int i = 0; i < n; i++) begin
            if (mode == 0) d = PDM_P1;
            else if (mode == 1) d = PDM_M1;
            else d = (i % 2 == 0) ? PDM_P1 : PDM_M1;
            step(1'b0, 1'b1, d, 2'b00);
            if (i == 0) first_e = drv_edge;
            last_e = drv_edge;
        end
    endtask

    initial begin
        int base;
        int f;
        int l;
        int f2;
        int l2;
        int hsum;
        int t [125];
        logic [1:0] d;
        logic [1:0] e;
        logic r;
        logic vv;

        // Build the CIC impulse response as four boxcar convolutions
        for (int i = 0; i < 125; i++) h[i] = 0;
        h[0] = 1;
        for (int s = 0; s < 4; s++) begin
            for (int i = 0; i < 125; i++) t[i] = 0;
            for (int i = 0; i < 125; i++)
                for (int j = 0; j < 32; j++)
                    if (i + j < 125) t[i+j] += h[i];
            for (int i = 0; i < 125; i++) h[i] = t[i];
        end
        hsum = 0;
        for (int i = 0; i < 125; i++) hsum += h[i];
        chk("model_gain", hsum, 1048576);
        chk("model_h_mid", h[62], 21856);

        // Constant +1
        do_reset(3);
        base = pulse_cyc.size();
        run(384, 0, f, l);
        idle(4);
        chk("p1_count", pulse_cyc.size() - base, 6);
        chk("p1_first_latency", qget(pulse_cyc, base) - f, 65);
        chk("p1_spacing", qget(pulse_cyc, base + 5) - qget(pulse_cyc, base + 4), 64);
        chk("p1_last_latency", qget(pulse_cyc, base + 5) - l, 2);
        chk("p1_data4", qget(pulse_dat, base + 3), 32767);
        chk("p1_data6", qget(pulse_dat, base + 5), 32767);
        chk("p1_err", qget(pulse_err, base + 5), 0);

        // Constant -1
        do_reset(2);
        base = pulse_cyc.size();
        run(384, 1, f, l);
        idle(4);
        chk("m1_data6", qget(pulse_dat, base + 5), -32768);

        // Alternating
        do_reset(2);
        base = pulse_cyc.size();
        run(384, 2, f, l);
        idle(4);
        chk("alt_data6", qget(pulse_dat, base + 5), 0);
        chk("alt_spacing", qget(pulse_cyc, base + 5) - qget(pulse_cyc, base + 4), 64);
        chk("alt_first_latency", qget(pulse_cyc, base) - f, 65);

        // Stall of 500 cycles mid-frame; error flags while invalid are ignored
        do_reset(2);
        base = pulse_cyc.size();
        run(100, 0, f, l);
        idle(3);
        for (int i = 0; i < 500; i++) step(1'b0, 1'b0, 2'($urandom_range(0, 3)), 2'b11);
        chk("stall_count", pulse_cyc.size() - base, 1);
        run(28, 0, f2, l2);
        idle(4);
        chk("stall_resume_count", pulse_cyc.size() - base, 2);
        chk("stall_resume_latency", qget(pulse_cyc, base + 1) - l2, 2);
        chk("stall_err", qget(pulse_err, base + 1), 0);

        // Error flag on one accepted sample
        do_reset(2);
        base = pulse_cyc.size();
        run(10, 0, f, l);
        step(1'b0, 1'b1, PDM_P1, 2'b10);
        run(53, 0, f, l);
        run(64, 0, f, l);
        idle(4);
        chk("err_frame", qget(pulse_err, base), 2);
        chk("err_next", qget(pulse_err, base + 1), 0);

        // Reset after 40 accepts discards the partial frame
        do_reset(2);
        run(40, 0, f, l);
        do_reset(3);
        base = pulse_cyc.size();
        run(64, 2, f, l);
        idle(4);
        chk("rst40_count", pulse_cyc.size() - base, 1);
        chk("rst40_latency", qget(pulse_cyc, base) - f, 65);

        // Reset together with the 64th valid sample suppresses the pulse
        do_reset(2);
        base = pulse_cyc.size();
        run(63, 0, f, l);
        step(1'b1, 1'b1, PDM_P1, 2'b00);
        idle(6);
        chk("simul_count", pulse_cyc.size() - base, 0);

        // Random traffic, including -2, 0, error flags and occasional resets
        do_reset(2);
        for (int i = 0; i < 4000; i++) begin
            r = ($urandom_range(0, 499) == 0);
            vv = ($urandom_range(0, 9) < 7);
            case ($urandom_range(0, 9))
                0, 1, 2, 3: d = PDM_P1;
                4, 5, 6, 7: d = PDM_M1;
                8:          d = 2'b10;
                default:    d = 2'b00;
            endcase
            e = ($urandom_range(0, 19) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            step(r, vv, d, e);
        end
        idle(4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
